// File: rtl/quad_signal_gen.sv
// Quadrature A/B encoder emulator: runs step commands, drives Gray-coded A/B and tracks wrapped position P.
// Optional index output Z is built when QSG_INDEX_EN is defined.
module quad_signal_gen #(
  parameter int PW     = 10,
  parameter int RATE_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [PW-1:0]     PPR,
  input  logic [RATE_W-1:0] rate,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [PW-1:0]     cmd_count,
  output logic              A,
  output logic              B,
  output logic [PW-1:0]     P,
  output logic              busy,
`ifdef QSG_INDEX_EN
  output logic              done,
  output logic              Z
`else
  output logic              done
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_PH2  = 3'd2;
  localparam logic [2:0] S_PH3  = 3'd3;
  localparam logic [2:0] S_PH4  = 3'd4;

  localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]       HALF_ONE = {{PW{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [RATE_W-1:0] r_timer;
  logic [RATE_W-1:0] r_rate_l;
  logic              r_dir;
  logic [PW-1:0]     r_rem;
  logic [PW-1:0]     r_ppr;
  logic [PW-1:0]     r_pos;
  logic              r_a;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              r_zero_pend;
`ifdef QSG_INDEX_EN
  logic              r_z;
`endif

  logic              w_accept;
  logic [RATE_W-1:0] w_rate_in_l;
  logic              w_phase_end;
  logic [PW:0]       w_half;
  logic signed [PW:0] w_max;
  logic signed [PW:0] w_min;
  logic signed [PW:0] w_pos_x;
  logic              w_degen;
  logic              w_wrap;
  logic [PW-1:0]     w_pos_nxt;

  assign w_accept    = cmd_valid && !r_busy;
  assign w_rate_in_l = (rate == '0) ? RATE_ONE : rate;
  assign w_phase_end = (r_timer == (r_rate_l - RATE_ONE));

  // Half of (PPR+1) without needing an extra-wide intermediate.
  assign w_half  = {2'b00, r_ppr[PW-1:1]} + {{PW{1'b0}}, r_ppr[0]};
  assign w_max   = w_half - HALF_ONE;
  assign w_min   = {(PW+1){1'b0}} - w_half;
  assign w_pos_x = {r_pos[PW-1], r_pos};
  assign w_degen = (w_min > w_max);

  always_comb begin
    w_wrap    = 1'b0;
    w_pos_nxt = r_pos;
    if (w_degen) begin
      w_pos_nxt = '0;
    end else if (r_dir) begin
      if (w_pos_x >= w_max) begin
        w_wrap    = 1'b1;
        w_pos_nxt = w_min[PW-1:0];
      end else begin
        w_pos_nxt = r_pos + CNT_ONE;
      end
    end else begin
      if (w_pos_x <= w_min) begin
        w_wrap    = 1'b1;
        w_pos_nxt = w_max[PW-1:0];
      end else begin
        w_pos_nxt = r_pos - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_rate_l    <= RATE_ONE;
      r_dir       <= 1'b0;
      r_rem       <= '0;
      r_ppr       <= '0;
      r_pos       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
`ifdef QSG_INDEX_EN
      r_z         <= 1'b0;
`endif
    end else begin
      r_done      <= r_zero_pend;
      r_zero_pend <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_ppr    <= PPR;
          r_rate_l <= w_rate_in_l;
          r_dir    <= cmd_dir;
          r_rem    <= cmd_count;
          r_timer  <= '0;
          if (cmd_count == '0) begin
            // Empty command still reports completion, one edge later.
            r_zero_pend <= 1'b1;
          end else begin
            r_state <= S_PH1;
            r_busy  <= 1'b1;
            r_a     <= cmd_dir;
            r_b     <= !cmd_dir;
          end
        end
      end else if (!w_phase_end) begin
        r_timer <= r_timer + RATE_ONE;
      end else begin
        r_timer <= '0;
        case (r_state)
          S_PH1: begin
            r_state <= S_PH2;
            r_a     <= 1'b1;
            r_b     <= 1'b1;
          end
          S_PH2: begin
            r_state <= S_PH3;
            r_a     <= !r_dir;
            r_b     <= r_dir;
          end
          S_PH3: begin
            r_state <= S_PH4;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_pos   <= w_pos_nxt;
            r_rem   <= r_rem - CNT_ONE;
`ifdef QSG_INDEX_EN
            r_z     <= w_wrap;
`endif
          end
          S_PH4: begin
`ifdef QSG_INDEX_EN
            r_z <= 1'b0;
`endif
            if (r_rem != '0) begin
              r_state <= S_PH1;
              r_a     <= r_dir;
              r_b     <= !r_dir;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef QSG_INDEX_EN
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap;
`else
  assign Z = r_z;
`endif

  assign A         = r_a;
  assign B         = r_b;
  assign P         = r_pos;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = !r_busy;

endmodule

// File: tb/tb_quad_signal_gen.sv
// Randomized and directed bench for quad_signal_gen against a cycle-indexed waveform model.
module tb_quad_signal_gen;
  localparam int PW     = 10;
  localparam int RATE_W = 16;
  localparam int VW     = PW + 5;

  logic              CLK = 1'b0;
  logic              reset;
  logic [PW-1:0]     PPR;
  logic [RATE_W-1:0] rate;
  logic              cmd_valid;
  logic              cmd_dir;
  logic [PW-1:0]     cmd_count;
  wire               cmd_ready;
  wire               A;
  wire               B;
  wire  [PW-1:0]     P;
  wire               busy;
  wire               done;
`ifdef QSG_INDEX_EN
  wire               Z;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_pos = 0;

  logic [VW-1:0] q_obs[$];
  logic [VW-1:0] q_exp[$];
  logic          q_obsz[$];
  logic          q_expz[$];

  always #5 CLK = ~CLK;

  quad_signal_gen #(.PW(PW), .RATE_W(RATE_W)) dut (
    .CLK(CLK), .reset(reset), .PPR(PPR), .rate(rate),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .A(A), .B(B), .P(P), .busy(busy),
`ifdef QSG_INDEX_EN
    .done(done), .Z(Z)
`else
    .done(done)
`endif
  );

  // Position after one step, from the signed-wrap rule with half = (PPR+1)/2.
  function automatic int step_pos(int pos, bit dir, int ppr, output bit wrapped);
    int half;
    int mx;
    int mn;
    half = (ppr + 1) / 2;
    mx = half - 1;
    mn = -half;
    wrapped = 1'b0;
    if (mn > mx) return 0;
    if (dir) begin
      if (pos >= mx) begin wrapped = 1'b1; return mn; end
      return pos + 1;
    end
    if (pos <= mn) begin wrapped = 1'b1; return mx; end
    return pos - 1;
  endfunction

  function automatic logic [1:0] ab_of(bit dir, int ph);
    case (ph)
      0: return dir ? 2'b10 : 2'b01;
      1: return 2'b11;
      2: return dir ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [PW-1:0] pw_of(int v);
    return PW'(v);
  endfunction

  // Issues one command and records observed/expected snapshots for every cycle through done.
  task automatic drive_cmd(bit dir, int count, int ppr, int rate_v, bit disturb);
    int r;
    int total;
    int ph;
    int c;
    int p;
    bit w;
    int pos_after[$];
    bit wr_after[$];
    logic [VW-1:0] e;
    logic ez;
    r = (rate_v == 0) ? 1 : rate_v;
    q_obs.delete(); q_exp.delete(); q_obsz.delete(); q_expz.delete();
    p = model_pos;
    pos_after.push_back(p);
    wr_after.push_back(1'b0);
    for (int i = 0; i < count; i++) begin
      p = step_pos(p, dir, ppr, w);
      pos_after.push_back(p);
      wr_after.push_back(w);
    end
    total = (count == 0) ? 1 : 4 * count * r;
    @(negedge CLK);
    cmd_dir   = dir;
    cmd_count = PW'(count);
    PPR       = PW'(ppr);
    rate      = RATE_W'(rate_v);
    cmd_valid = 1'b1;
    @(negedge CLK);
    for (int k = 0; k <= total; k++) begin
      ez = 1'b0;
      if (count == 0) begin
        e = {2'b00, pw_of(model_pos), 1'b0, 1'(k == total), 1'b1};
      end else if (k < total) begin
        ph = (k / r) % 4;
        c  = k / (4 * r);
        e  = {ab_of(dir, ph), pw_of(pos_after[(ph == 3) ? c + 1 : c]), 1'b1, 1'b0, 1'b0};
        ez = (ph == 3) && wr_after[c + 1];
      end else begin
        e = {2'b00, pw_of(pos_after[count]), 1'b0, 1'b1, 1'b1};
      end
      q_obs.push_back({A, B, P, busy, done, cmd_ready});
      q_exp.push_back(e);
`ifdef QSG_INDEX_EN
      q_obsz.push_back(Z);
`else
      q_obsz.push_back(1'b0);
`endif
      q_expz.push_back(ez);
      if (disturb && count > 0 && k < total - 1) begin
        cmd_valid = 1'b1;
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_count = PW'($urandom_range(1, 9));
        PPR       = PW'($urandom_range(0, 50));
        rate      = RATE_W'($urandom_range(0, 7));
      end else begin
        cmd_valid = 1'b0;
      end
      if (k < total) @(negedge CLK);
    end
    model_pos = pos_after[count];
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = '0; PPR = '0; rate = '0;
    #12;
    n_checks++;
    if ({A, B, P, busy, done, cmd_ready} !== {2'b00, {PW{1'b0}}, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", {A, B, P, busy, done, cmd_ready}, {2'b00, {PW{1'b0}}, 3'b001});
    end
    @(negedge CLK);
    reset = 1'b1;
    model_pos = 0;
    @(negedge CLK);
    n_checks++;
    if ({A, B, P, busy, done, cmd_ready} !== {2'b00, {PW{1'b0}}, 3'b001}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h want %h", {A, B, P, busy, done, cmd_ready}, {2'b00, {PW{1'b0}}, 3'b001});
    end
  endtask

  task automatic test_basic_inc;
    drive_cmd(1'b1, 2, 99, 3, 1'b0);
    n_checks++;
    if (q_obs.size() !== 25) begin
      n_fail++;
      $display("FAIL basic_len: got %0d want 25", q_obs.size());
    end
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
    n_checks++;
    if (P !== 10'd2) begin
      n_fail++;
      $display("FAIL basic_final_P: got %0d want 2", P);
    end
  endtask

  task automatic test_wrap_dec;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    model_pos = 0;
    drive_cmd(1'b0, 6, 9, 1, 1'b0);
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL wrap_dec cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
`ifdef QSG_INDEX_EN
      n_checks++;
      if (q_obsz[k] !== q_expz[k]) begin
        n_fail++;
        $display("FAIL wrap_dec_Z cycle %0d: got %b want %b", k, q_obsz[k], q_expz[k]);
      end
`endif
    end
    n_checks++;
    if (P !== 10'd4) begin
      n_fail++;
      $display("FAIL wrap_dec_final_P: got %0d want 4", $signed(P));
    end
  endtask

  task automatic test_wrap_inc;
    drive_cmd(1'b1, 1, 9, 2, 1'b0);
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL wrap_inc cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
    n_checks++;
    if ($signed(P) !== -10'sd5) begin
      n_fail++;
      $display("FAIL wrap_inc_final_P: got %0d want -5", $signed(P));
    end
  endtask

  task automatic test_rate_zero_and_empty;
    drive_cmd(1'b0, 1, 30, 0, 1'b0);
    n_checks++;
    if (q_obs.size() !== 5) begin
      n_fail++;
      $display("FAIL rate0_len: got %0d want 5", q_obs.size());
    end
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL rate0 cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
    drive_cmd(1'b1, 0, 30, 4, 1'b0);
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL empty_cmd cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    drive_cmd(1'b1, 3, 11, 2, 1'b1);
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL busy_ignore cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    cmd_dir = 1'b1; cmd_count = 10'd5; PPR = 10'd40; rate = 16'd2; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({A, B, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mid_in_ph2: got %b want 111", {A, B, busy});
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({A, B, P, busy, done, cmd_ready} !== {2'b00, {PW{1'b0}}, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want %h", {A, B, P, busy, done, cmd_ready}, {2'b00, {PW{1'b0}}, 3'b001});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 2) reset = 1'b1;
      n_checks++;
      if ({A, B, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid_hold %0d: got %b want 0000", i, {A, B, busy, done});
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({A, B, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid_no_resume %0d: got %b want 0000", i, {A, B, busy, done});
      end
    end
    model_pos = 0;
    drive_cmd(1'b0, 2, 15, 1, 1'b0);
    for (int k = 0; k < q_obs.size(); k++) begin
      n_checks++;
      if (q_obs[k] !== q_exp[k]) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: got %h want %h", k, q_obs[k], q_exp[k]);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 14; n++) begin
      drive_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int k = 0; k < q_obs.size(); k++) begin
        n_checks++;
        if (q_obs[k] !== q_exp[k]) begin
          n_fail++;
          $display("FAIL random cmd %0d cycle %0d: got %h want %h", n, k, q_obs[k], q_exp[k]);
        end
`ifdef QSG_INDEX_EN
        n_checks++;
        if (q_obsz[k] !== q_expz[k]) begin
          n_fail++;
          $display("FAIL random_Z cmd %0d cycle %0d: got %b want %b", n, k, q_obsz[k], q_expz[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_inc();
    test_wrap_dec();
    test_wrap_inc();
    test_rate_zero_and_empty();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
